// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues req/ack instruction fetches and
// drives the IF/ID payload, with one-entry stall buffering and redirect draining.
module fetch_sequencer #(
  parameter int unsigned              ADDR_W   = 8,
  parameter int unsigned              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]        RESET_PC = 8'h00,
  parameter int unsigned              PC_STEP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ifid_valid,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_next_pc,
  output logic [INSTR_W-1:0] ifid_instr
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_inc;
  logic [INSTR_W-1:0] buf_instr;
  logic               ack_v;

  assign pc_inc = pc + STEP;
  // An ack only counts while a request is actually outstanding.
  assign ack_v  = imem_ack & imem_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      ifid_valid   <= 1'b0;
      ifid_pc      <= '0;
      ifid_next_pc <= '0;
      ifid_instr   <= '0;
      buf_instr    <= '0;
    end else begin
      // Decode consumes the payload whenever it is not stalled.
      if (!stall) ifid_valid <= 1'b0;
      case (state)
        FETCH: begin
          if (redirect) begin
            pc         <= redirect_addr;
            ifid_valid <= 1'b0;
            // An unacked outstanding request must be drained at its old address.
            if (ack_v || !imem_req) begin
              imem_req  <= 1'b1;
              imem_addr <= redirect_addr;
            end else begin
              state <= DRAIN;
            end
          end else if (ack_v) begin
            if (stall) begin
              buf_instr <= imem_rdata;
              imem_req  <= 1'b0;
              state     <= HOLD;
            end else begin
              ifid_valid   <= 1'b1;
              ifid_pc      <= pc;
              ifid_next_pc <= pc_inc;
              ifid_instr   <= imem_rdata;
              pc           <= pc_inc;
              imem_addr    <= pc_inc;
            end
          end else begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc         <= redirect_addr;
            ifid_valid <= 1'b0;
            imem_req   <= 1'b1;
            imem_addr  <= redirect_addr;
            state      <= FETCH;
          end else if (!stall) begin
            ifid_valid   <= 1'b1;
            ifid_pc      <= pc;
            ifid_next_pc <= pc_inc;
            ifid_instr   <= buf_instr;
            pc           <= pc_inc;
            imem_req     <= 1'b1;
            imem_addr    <= pc_inc;
            state        <= FETCH;
          end
        end
        DRAIN: begin
          if (redirect) begin
            pc         <= redirect_addr;
            ifid_valid <= 1'b0;
          end
          if (ack_v) begin
            imem_req  <= 1'b1;
            imem_addr <= redirect ? redirect_addr : pc;
            state     <= FETCH;
          end
        end
        default: begin
          state    <= FETCH;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
